// File: rtl/bcd_bin2bcd_seq.sv
// Sequential binary to packed BCD converter (double dabble, one bit per clock).
// Optional macro BCD_B2B_SIGNED_EN: two's complement input, magnitude plus sign.
module bcd_bin2bcd_seq #(
  parameter int WID = 32,
  parameter int N   = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WID-1:0] i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*4-1:0] o,
  output logic           sign
);

  localparam int CW    = (WID > 1) ? $clog2(WID) : 1;
  localparam int MIN_N = (WID * 30103) / 100000 + 1;

  if (N < MIN_N) begin : g_chk
    $error("bcd_bin2bcd_seq: N too small for WID");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         nxt;
  logic [CW-1:0]  cnt;
  logic [WID-1:0] bin;
  logic [N*4-1:0] bcd;
  logic [N*4-1:0] adj;
  logic [N*4-1:0] bcd_nxt;
  logic           accept;
  logic           last;
  logic [WID-1:0] mag;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == '0);

`ifdef BCD_B2B_SIGNED_EN
  logic neg;
  logic sign_q;
  // unsigned WID-bit magnitude so the most negative value converts exactly
  assign mag  = i[WID-1] ? (~i + WID'(1)) : i;
  assign sign = sign_q;
`else
  assign mag  = i;
  assign sign = 1'b0;
`endif

  always_comb begin
    adj = bcd;
    for (int d = 0; d < N; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) begin
        adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
    end
    bcd_nxt = (adj << 1) | {{(N*4-1){1'b0}}, bin[WID-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = SHIFT;
      SHIFT:   if (last) nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      bin <= '0;
      bcd <= '0;
      o   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            bin <= mag;
            bcd <= '0;
            cnt <= CW'(WID - 1);
          end
        end
        SHIFT: begin
          bcd <= bcd_nxt;
          bin <= bin << 1;
          cnt <= cnt - CW'(1);
          if (last) o <= bcd_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_B2B_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg    <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      if (accept) neg <= i[WID-1];
      if (state == SHIFT && last) sign_q <= neg;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_bin2bcd_seq.sv
// Directed bench for bcd_bin2bcd_seq (default WID=32, N=10).
// Build with +define+BCD_B2B_SIGNED_EN to check the signed variant.
module tb_bcd_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] i;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] o;
  logic        sign;

  int total;
  int bad;

  bcd_bin2bcd_seq #(.WID(32), .N(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i         (i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .sign      (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept v, wait for out_valid, leave result pending
  task automatic conv(input string tag, input logic [31:0] v,
                      input logic [39:0] eo, input logic es);
    int lat;
    chk({tag, ".rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    i        = v;
    tick();
    in_valid = 1'b0;
    i        = 32'h5a5a5a5a;
    chk({tag, ".busy"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'd32);
    chk({tag, ".o"}, 64'(o), 64'(eo));
    chk({tag, ".sign"}, 64'(sign), 64'(es));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int rise [$];
    logic [39:0] got [$];
    int c;
    int seen;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    i         = '0;
    repeat (3) tick();
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.o", 64'(o), 64'd0);
    chk("rst.sign", 64'(sign), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    conv("zero", 32'd0, 40'h0000000000, 1'b0);
    drain();

`ifdef BCD_B2B_SIGNED_EN
    conv("ones", 32'hFFFFFFFF, 40'h0000000001, 1'b1);
    drain();
    conv("min", 32'h80000000, 40'h2147483648, 1'b1);
    drain();
`else
    conv("ones", 32'hFFFFFFFF, 40'h4294967295, 1'b0);
    drain();
    conv("min", 32'h80000000, 40'h2147483648, 1'b0);
    drain();
`endif

    conv("stall", 32'd123456789, 40'h0123456789, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stall.ov", 64'(out_valid), 64'd1);
      chk("stall.o", 64'(o), 64'h0123456789);
      chk("stall.ir", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall.ov_drop", 64'(out_valid), 64'd0);
    chk("stall.ir_back", 64'(in_ready), 64'd1);
    chk("stall.o_kept", 64'(o), 64'h0123456789);

    // back-to-back: in_valid held, i switched after first acceptance
    out_ready = 1'b1;
    in_valid  = 1'b1;
    i         = 32'd99;
    seen      = 0;
    c         = 0;
    while (c < 200 && rise.size() < 2) begin
      tick();
      c++;
      if (!in_ready && seen == 0) begin
        seen = 1;
        i    = 32'd100;
      end else if (!in_ready && seen == 2) begin
        seen     = 3;
        in_valid = 1'b0;
      end else if (in_ready && seen == 1) begin
        seen = 2;
      end
      if (out_valid) begin
        rise.push_back(c);
        got.push_back(o);
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b.count", 64'(rise.size()), 64'd2);
    if (rise.size() == 2) begin
      chk("b2b.o0", 64'(got[0]), 64'h0000000099);
      chk("b2b.o1", 64'(got[1]), 64'h0000000100);
      chk("b2b.gap", 64'(rise[1] - rise[0]), 64'd34);
    end

    // reset in the middle of a conversion
    in_valid = 1'b1;
    i        = 32'd12345;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    rst_n = 1'b0;
    #1;
    chk("mid.ov", 64'(out_valid), 64'd0);
    chk("mid.o", 64'(o), 64'd0);
    chk("mid.ir", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    chk("mid.no_result", 64'(seen), 64'd0);

    conv("after", 32'd9999, 40'h0000009999, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
